ps2_keyboard_decoder: RTL
=========================

Name: ps2_keyboard_decoder

Overview:
Consumes raw set-2 scan code bytes from the ps2 link block (scan_code_valid/ready/data) and turns them into single key events: code, extended flag, release flag. Tracks shift/ctrl/alt and the three lock states. Drives the ps2 link's command port to send the 0xED LED update sequence. Sits between ps2 and the terminal's keymap/translation stage.

Parameters:
TIMEOUT_BITS, 20, ACK wait counter width; timeout fires when the counter is all ones (about 20 ms at 51.8 MHz).

Ports:
clk  in  1  system clock
reset_low  in  1  asynchronous active-low reset
link_error  in  1  error level from ps2; rising edge aborts any partial sequence
scan_code_valid  in  1  byte available from ps2
scan_code_data  in  8  received byte
scan_code_ready  out  1  decoder accepts byte
key_valid  out  1  key event available
key_ready  in  1  consumer accepts event
key_code  out  8  final (unprefixed) scan code
key_extended  out  1  code was E0-prefixed (also set for Pause)
key_release  out  1  code was F0-prefixed
mod_shift, mod_ctrl, mod_alt  out  1 each  left OR right modifier held
caps_lock, num_lock, scroll_lock  out  1 each  lock toggle state
command_valid  out  1  byte for ps2 to transmit
command_data  out  8  byte to transmit
command_ready  in  1  ps2 idle, will take byte
led_error  out  1  one-cycle pulse on ACK timeout

Behaviour:
- Reset (async, reset_low=0): all outputs 0; prefix flags, pause counter, modifier/lock registers, LED FSM (L_IDLE), pending flag and timeout counter cleared.
- scan_code_ready = ~key_valid. A byte is consumed when valid && ready.
- Byte handling, in priority order:
  - 0xFA, 0xFE, 0xAA, 0xEE, 0x00, 0xFC, 0xFF: never produce events. 0xFA/0xFE are routed to the LED FSM.
  - 0xE1: start pause skip; the next 7 bytes are swallowed. After the 7th, emit code=0x77, extended=1, release=0.
  - 0xE0: set ext flag.
  - 0xF0: set brk flag.
  - Any other byte: emit an event with code=byte, extended=ext, release=brk, then clear both flags.
  - Exception: extended 0x12 or 0x59 (fake shift) is dropped and clears the flags without an event.
- Event timing: key_valid rises the cycle after the final byte is accepted. code/flags are held stable until key_valid && key_ready. key_valid drops the following cycle.
- Modifiers update when the event is generated (not when it is accepted):
  - Shift: L=0x12, R=0x59 (non-extended only).
  - Ctrl: L=0x14, R=E0 0x14.
  - Alt: L=0x11, R=E0 0x11.
  - Left and right are tracked separately. Make sets, break clears. Outputs are the OR of left and right.
- Locks toggle on make only:
  - caps = 0x58, num = non-extended 0x77, scroll = 0x7E.
  - Typematic repeat makes toggle again; this is intended.
  - Each toggle sets the pending flag.
- LED FSM:
  - L_IDLE: if pending, clear pending and go to L_SEND_ED.
  - L_SEND_ED: command_valid=1, data=0xED. On command_ready, go to L_WAIT_ACK1 and clear the counter.
  - L_WAIT_ACK1: 0xFA goes to L_SEND_LED; 0xFE goes back to L_SEND_ED.
  - L_SEND_LED: data = {5'b0, caps, num, scroll}, sampled on entry. On command_ready, go to L_WAIT_ACK2.
  - L_WAIT_ACK2: 0xFA goes to L_IDLE; 0xFE goes back to L_SEND_LED.
  - Counter saturation in either WAIT state: pulse led_error, go to L_IDLE.
  - A toggle during an update sets pending, so a second full sequence follows.
- command_valid is a combinational decode of the SEND states. It drops the cycle after command_ready is sampled high.
- link_error rising edge: clear ext, brk and pause skip. Does not affect the LED FSM, modifiers or a pending key_valid.
- A prefix arriving during pause skip is swallowed like any other byte.

Test Plan:
1. 0x1C -> one event code=0x1C ext=0 rel=0. Then E0 F0 0x75 -> code=0x75 ext=1 rel=1. No event for the prefixes.
2. 0x12, then F0 0x12 -> mod_shift 1 after the first event, 0 after the break. E0 0x14 with L-ctrl held, then F0 0x14 -> mod_ctrl stays 1 (right still held).
3. E1 14 77 E1 F0 14 F0 77 -> exactly one event code=0x77 ext=1 rel=0; num_lock unchanged.
4. 0x58 make -> caps_lock=1; command 0xED, 0xFA, command 0x04, 0xFA -> L_IDLE, no key events for 0xFA.
5. Same as 4 but reply 0xFE to the LED byte -> 0x04 resent. No reply at all -> led_error pulse after 2^20-1 cycles, FSM idle.
6. key_ready held 0 while 3 bytes are offered -> scan_code_ready=0, first event held stable, no byte lost. Assert reset_low mid-E0 sequence -> flags cleared, next byte 0x1C gives ext=0.

Source files
------------

// File: rtl/ps2_keyboard_decoder_if.sv
// rtl/ps2_keyboard_decoder_if.sv - scan code, key event and command streams of the keyboard decoder
interface ps2_keyboard_decoder_if;
  logic       scan_code_valid;
  logic       scan_code_ready;
  logic [7:0] scan_code_data;

  logic       key_valid;
  logic       key_ready;
  logic [7:0] key_code;
  logic       key_extended;
  logic       key_release;

  logic       command_valid;
  logic       command_ready;
  logic [7:0] command_data;

  modport master (
    input  scan_code_valid, scan_code_data, key_ready, command_ready,
    output scan_code_ready, key_valid, key_code, key_extended, key_release,
           command_valid, command_data
  );

  modport slave (
    output scan_code_valid, scan_code_data, key_ready, command_ready,
    input  scan_code_ready, key_valid, key_code, key_extended, key_release,
           command_valid, command_data
  );
endinterface

// File: rtl/ps2_keyboard_decoder.sv
// rtl/ps2_keyboard_decoder.sv - set-2 scan code to key event decoder with modifier, lock and LED tracking
module ps2_keyboard_decoder #(
  parameter int TIMEOUT_BITS = 20
) (
  input  logic                   clk,
  input  logic                   reset_low,
  input  logic                   link_error,
  ps2_keyboard_decoder_if.master bus,
  output logic                   mod_shift,
  output logic                   mod_ctrl,
  output logic                   mod_alt,
  output logic                   caps_lock,
  output logic                   num_lock,
  output logic                   scroll_lock,
  output logic                   led_error
);

  typedef enum logic [2:0] {
    L_IDLE,
    L_SEND_ED,
    L_WAIT_ACK1,
    L_SEND_LED,
    L_WAIT_ACK2
  } led_state_t;

  logic       key_valid_q;
  logic [7:0] key_code_q;
  logic       key_ext_q;
  logic       key_rel_q;

  logic       ext_q, brk_q;
  logic [2:0] pause_cnt;
  logic       link_error_q;

  logic       shift_l, shift_r, ctrl_l, ctrl_r, alt_l, alt_r;
  logic       pending;

  led_state_t                led_state, led_next;
  logic [TIMEOUT_BITS-1:0]   ack_cnt;
  logic [7:0]                led_data;

  logic       accept;
  logic [7:0] byte_in;
  logic       is_ignored;
  logic       link_rise;

  logic       ev_fire;
  logic [7:0] ev_code;
  logic       ev_ext, ev_rel;
  logic       ext_d, brk_d;
  logic [2:0] pause_d;
  logic       lock_toggle;

  logic       ack_byte, nak_byte, timeout;
  logic       clr_pending, cnt_clr;

  assign bus.scan_code_ready = ~key_valid_q;
  assign bus.key_valid       = key_valid_q;
  assign bus.key_code        = key_code_q;
  assign bus.key_extended    = key_ext_q;
  assign bus.key_release     = key_rel_q;

  assign accept    = bus.scan_code_valid && ~key_valid_q;
  assign byte_in   = bus.scan_code_data;
  assign link_rise = link_error && !link_error_q;

  assign is_ignored = (byte_in == 8'hFA) || (byte_in == 8'hFE) || (byte_in == 8'hAA) ||
                      (byte_in == 8'hEE) || (byte_in == 8'h00) || (byte_in == 8'hFC) ||
                      (byte_in == 8'hFF);

  always_comb begin
    ev_fire = 1'b0;
    ev_code = byte_in;
    ev_ext  = ext_q;
    ev_rel  = brk_q;
    ext_d   = ext_q;
    brk_d   = brk_q;
    pause_d = pause_cnt;
    if (accept) begin
      if (is_ignored) begin
        ev_fire = 1'b0;
      end else if (pause_cnt != 3'd0) begin
        // Pause is E1 14 77 E1 F0 14 F0 77; only the last byte yields an event
        pause_d = pause_cnt - 3'd1;
        if (pause_cnt == 3'd1) begin
          ev_fire = 1'b1;
          ev_code = 8'h77;
          ev_ext  = 1'b1;
          ev_rel  = 1'b0;
        end
      end else if (byte_in == 8'hE1) begin
        pause_d = 3'd7;
        ext_d   = 1'b0;
        brk_d   = 1'b0;
      end else if (byte_in == 8'hE0) begin
        ext_d = 1'b1;
      end else if (byte_in == 8'hF0) begin
        brk_d = 1'b1;
      end else begin
        ext_d   = 1'b0;
        brk_d   = 1'b0;
        // E0 12 / E0 59 are fake shifts wrapped around some extended keys
        ev_fire = !(ext_q && ((byte_in == 8'h12) || (byte_in == 8'h59)));
      end
    end
    if (link_rise) begin
      ext_d   = 1'b0;
      brk_d   = 1'b0;
      pause_d = 3'd0;
    end
  end

  assign lock_toggle = ev_fire && !ev_rel &&
                       ((ev_code == 8'h58) || (!ev_ext && (ev_code == 8'h77)) ||
                        (ev_code == 8'h7E));

  always_ff @(posedge clk or negedge reset_low) begin
    if (!reset_low) begin
      key_valid_q  <= 1'b0;
      key_code_q   <= 8'h00;
      key_ext_q    <= 1'b0;
      key_rel_q    <= 1'b0;
      ext_q        <= 1'b0;
      brk_q        <= 1'b0;
      pause_cnt    <= 3'd0;
      link_error_q <= 1'b0;
    end else begin
      ext_q        <= ext_d;
      brk_q        <= brk_d;
      pause_cnt    <= pause_d;
      link_error_q <= link_error;
      if (ev_fire) begin
        key_valid_q <= 1'b1;
        key_code_q  <= ev_code;
        key_ext_q   <= ev_ext;
        key_rel_q   <= ev_rel;
      end else if (key_valid_q && bus.key_ready) begin
        key_valid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_low) begin
    if (!reset_low) begin
      shift_l     <= 1'b0;
      shift_r     <= 1'b0;
      ctrl_l      <= 1'b0;
      ctrl_r      <= 1'b0;
      alt_l       <= 1'b0;
      alt_r       <= 1'b0;
      caps_lock   <= 1'b0;
      num_lock    <= 1'b0;
      scroll_lock <= 1'b0;
      pending     <= 1'b0;
    end else begin
      if (ev_fire) begin
        if (!ev_ext && ev_code == 8'h12) shift_l <= !ev_rel;
        if (!ev_ext && ev_code == 8'h59) shift_r <= !ev_rel;
        if (!ev_ext && ev_code == 8'h14) ctrl_l  <= !ev_rel;
        if ( ev_ext && ev_code == 8'h14) ctrl_r  <= !ev_rel;
        if (!ev_ext && ev_code == 8'h11) alt_l   <= !ev_rel;
        if ( ev_ext && ev_code == 8'h11) alt_r   <= !ev_rel;
      end
      if (ev_fire && !ev_rel) begin
        if (ev_code == 8'h58)             caps_lock   <= !caps_lock;
        if (!ev_ext && ev_code == 8'h77)  num_lock    <= !num_lock;
        if (ev_code == 8'h7E)             scroll_lock <= !scroll_lock;
      end
      // A toggle in the same cycle the FSM takes the flag must not be lost
      pending <= (pending && !clr_pending) || lock_toggle;
    end
  end

  assign mod_shift = shift_l || shift_r;
  assign mod_ctrl  = ctrl_l || ctrl_r;
  assign mod_alt   = alt_l || alt_r;

  assign ack_byte = accept && (byte_in == 8'hFA);
  assign nak_byte = accept && (byte_in == 8'hFE);
  assign timeout  = &ack_cnt;

  always_comb begin
    led_next          = led_state;
    clr_pending       = 1'b0;
    cnt_clr           = 1'b0;
    led_error         = 1'b0;
    bus.command_valid = 1'b0;
    bus.command_data  = 8'h00;
    case (led_state)
      L_IDLE: begin
        if (pending) begin
          clr_pending = 1'b1;
          led_next    = L_SEND_ED;
        end
      end
      L_SEND_ED: begin
        bus.command_valid = 1'b1;
        bus.command_data  = 8'hED;
        if (bus.command_ready) begin
          led_next = L_WAIT_ACK1;
          cnt_clr  = 1'b1;
        end
      end
      L_WAIT_ACK1: begin
        if (ack_byte) begin
          led_next = L_SEND_LED;
        end else if (nak_byte) begin
          led_next = L_SEND_ED;
        end else if (timeout) begin
          led_error = 1'b1;
          led_next  = L_IDLE;
        end
      end
      L_SEND_LED: begin
        bus.command_valid = 1'b1;
        bus.command_data  = led_data;
        if (bus.command_ready) begin
          led_next = L_WAIT_ACK2;
          cnt_clr  = 1'b1;
        end
      end
      L_WAIT_ACK2: begin
        if (ack_byte) begin
          led_next = L_IDLE;
        end else if (nak_byte) begin
          led_next = L_SEND_LED;
        end else if (timeout) begin
          led_error = 1'b1;
          led_next  = L_IDLE;
        end
      end
      default: led_next = L_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_low) begin
    if (!reset_low) begin
      led_state <= L_IDLE;
      ack_cnt   <= '0;
      led_data  <= 8'h00;
    end else begin
      led_state <= led_next;
      if (cnt_clr) begin
        ack_cnt <= '0;
      end else if ((led_state == L_WAIT_ACK1 || led_state == L_WAIT_ACK2) && !timeout) begin
        ack_cnt <= ack_cnt + TIMEOUT_BITS'(1);
      end
      if (led_next == L_SEND_LED && led_state != L_SEND_LED) begin
        led_data <= {5'b00000, caps_lock, num_lock, scroll_lock};
      end
    end
  end

endmodule
